// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read path (AR + R) among four masters.
// One burst is outstanding at a time. The grant is tagged downstream as a
// one-hot ARID: master 0 = 4'b1000 ... master 3 = 4'b0001.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [3:0]          m_arvalid,
    input  logic [4*ADDR_W-1:0] m_araddr,
    input  logic [4*8-1:0]      m_arlen,
    input  logic [4*3-1:0]      m_arsize,
    input  logic [4*2-1:0]      m_arburst,
    output logic [3:0]          m_arready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    output logic                m_rlast,
    output logic [3:0]          m_rvalid,
    input  logic [3:0]          m_rready,
    output logic [3:0]          s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic                busy,
    output logic [3:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] gidx;
    logic [1:0] cand;
    logic [1:0] pick_idx;
    logic       pick_vld;

    // Granted master index recovered from the one-hot grant (bit 3 = master 0).
    assign gidx = {grant[1] | grant[0], grant[2] | grant[0]};

    assign busy = (state != IDLE);

    // Round-robin pick: first requester scanning ptr, ptr+1, ... mod 4.
    // Scanning from the far end lets the nearest requester win last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr;
        cand     = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (m_arvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= 2'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic: grant in IDLE, AR handshake in ADDR, last beat in DATA.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = 4'b1000 >> pick_idx;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (s_arvalid && s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (s_rvalid && s_rready && s_rlast) begin
                    ptr_nxt   = gidx + 2'd1;
                    grant_nxt = 4'b0000;
                    state_nxt = IDLE;
                end
            end
            default: begin
                grant_nxt = 4'b0000;
                state_nxt = IDLE;
            end
        endcase
    end

    // Channel routing: AR fields only in ADDR, R path only in DATA, zeros otherwise.
    always_comb begin
        m_arready = 4'b0000;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_rvalid  = 4'b0000;
        s_arid    = 4'b0000;
        s_araddr  = '0;
        s_arlen   = 8'd0;
        s_arsize  = 3'd0;
        s_arburst = 2'd0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state)
            ADDR: begin
                s_arid          = grant;
                s_araddr        = m_araddr[int'(gidx)*ADDR_W +: ADDR_W];
                s_arlen         = m_arlen[int'(gidx)*8 +: 8];
                s_arsize        = m_arsize[int'(gidx)*3 +: 3];
                s_arburst       = m_arburst[int'(gidx)*2 +: 2];
                s_arvalid       = m_arvalid[gidx];
                m_arready[gidx] = s_arready;
            end
            DATA: begin
                m_rdata        = s_rdata;
                m_rresp        = s_rresp;
                m_rlast        = s_rlast;
                m_rvalid[gidx] = s_rvalid;
                s_rready       = m_rready[gidx];
            end
            default: begin
            end
        endcase
    end

endmodule
